uno_var_gen_pipe: RTL and testbench

//  Multi-lane, 2-stage pipelined variable generator for the PE unary (uno) datapath. Per lane:
//  - div/log: normalises x to [0.5,1) and outputs var = 0.75 - x_norm plus the signed normalisation shift.
//  - exp: splits x into floor integer and non-negative fraction.

---
 rtl/uno_pkg.sv | 23 ++
 rtl/lead_one_enc.sv | 21 ++
 rtl/uno_var_gen_pipe.sv | 158 +++++++++++++++
 tb/tb_uno_var_gen_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uno_pkg.sv
// Shared definitions for the PE unary (uno) datapath: mode encoding,
// default Q-format widths and the 0.75 normalisation constant.
package uno_pkg;

  typedef enum logic [1:0] {
    UNO_GEMM = 2'b00,
    UNO_DIV  = 2'b01,
    UNO_EXP  = 2'b10,
    UNO_LOG  = 2'b11
  } uno_mode_e;

  localparam int UNO_INT_BW = 5;
  localparam int UNO_FRA_BW = 10;
  localparam int UNO_MUL_BW = 1 + UNO_INT_BW + UNO_FRA_BW;

  // 0.75 in a Q format with fra fraction bits (0b11 followed by fra-2 zeros)
  function automatic int point_075(input int fra);
    return 3 << (fra - 2);
  endfunction

  localparam int POINT_075 = point_075(UNO_FRA_BW);

endpackage

// File: rtl/lead_one_enc.sv
// Combinational leading-one encoder: index of the most significant set bit
// of i_x, plus a flag for the all-zero input (o_pos is 0 in that case).
module lead_one_enc #(
  parameter int  W  = 16,
  localparam int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_x,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_x[i]) o_pos = PW'(i);
    end
  end

  assign o_zero = (i_x == '0);

endmodule

// File: rtl/uno_var_gen_pipe.sv
// Two-stage, multi-lane variable generator for div/log (normalise, 0.75 - x_norm)
// and exp (floor/fraction split). Define UNO_VAR_GEN_EXC_EN to add exc_o flags.
module uno_var_gen_pipe
  import uno_pkg::*;
#(
  parameter int  LANES  = 4,
  parameter int  INT_BW = UNO_INT_BW,
  parameter int  FRA_BW = UNO_FRA_BW,
  localparam int MUL_BW = 1 + INT_BW + FRA_BW,
  localparam int SH_BW  = $clog2(MUL_BW) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  gemm_uno,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*MUL_BW-1:0]     x_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*MUL_BW-1:0]     var_o,
  output logic [LANES*SH_BW-1:0]      shift_o,
  output logic [LANES*(INT_BW+1)-1:0] int_o,
  output logic [1:0]                  mode_o
`ifdef UNO_VAR_GEN_EXC_EN
  ,
  output logic [LANES-1:0]            exc_o
`endif
);

  localparam int                PW   = $clog2(MUL_BW);
  localparam logic [MUL_BW-1:0] P075 = MUL_BW'(point_075(FRA_BW));

  function automatic logic [MUL_BW-1:0] norm_x(input logic [MUL_BW-1:0]       x,
                                               input logic signed [SH_BW-1:0] sh);
    logic [SH_BW-1:0] amt;
    amt = sh[SH_BW-1] ? $unsigned(-sh) : $unsigned(sh);
    return sh[SH_BW-1] ? (x >> amt) : (x << amt);
  endfunction

  logic                     r_vld_p1, r_vld_p2;
  logic                     w_adv_p1, w_adv_p2;
  uno_mode_e                r_mode_p1, r_mode_p2;
  logic [MUL_BW-1:0]        r_x_p1    [LANES];
  logic signed [SH_BW-1:0]  r_sh_p1   [LANES];
  logic [PW-1:0]            w_pos     [LANES];
  logic                     w_zero    [LANES];
  logic signed [SH_BW-1:0]  w_sh_p1   [LANES];
  logic signed [MUL_BW-1:0] w_var_p2  [LANES];
  logic signed [SH_BW-1:0]  w_sh_p2   [LANES];
  logic signed [INT_BW:0]   w_int_p2  [LANES];
  logic signed [MUL_BW-1:0] r_var_p2  [LANES];
  logic signed [SH_BW-1:0]  r_sh_p2   [LANES];
  logic signed [INT_BW:0]   r_int_p2  [LANES];

  assign w_adv_p2 = !r_vld_p2 || out_ready;
  assign w_adv_p1 = !r_vld_p1 || w_adv_p2;
  assign in_ready = w_adv_p1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lead_one_enc #(.W(MUL_BW)) u_loe (
      .i_x    (x_i[l*MUL_BW +: MUL_BW]),
      .o_pos  (w_pos[l]),
      .o_zero (w_zero[l])
    );
    assign w_sh_p1[l] = w_zero[l] ? '0 : SH_BW'(FRA_BW - 1) - SH_BW'(w_pos[l]);

    assign var_o[l*MUL_BW +: MUL_BW]            = r_var_p2[l];
    assign shift_o[l*SH_BW +: SH_BW]            = r_sh_p2[l];
    assign int_o[l*(INT_BW+1) +: (INT_BW+1)]    = r_int_p2[l];
  end

  // ---- stage 1: capture operands, mode and per-lane normalisation shift ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv_p1) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv_p1 && in_valid) begin
      r_mode_p1 <= uno_mode_e'(gemm_uno);
      for (int l = 0; l < LANES; l++) begin
        r_x_p1[l]  <= x_i[l*MUL_BW +: MUL_BW];
        r_sh_p1[l] <= w_sh_p1[l];
      end
    end
  end

  // ---- stage 2: mode-dependent var / shift / int ----
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_var_p2[l] = '0;
      w_sh_p2[l]  = '0;
      w_int_p2[l] = '0;
      unique case (r_mode_p1)
        UNO_DIV, UNO_LOG: begin
          w_var_p2[l] = P075 - norm_x(r_x_p1[l], r_sh_p1[l]);
          w_sh_p2[l]  = r_sh_p1[l];
        end
        UNO_EXP: begin
          w_int_p2[l] = r_x_p1[l][MUL_BW-1:FRA_BW];
          w_var_p2[l] = MUL_BW'(r_x_p1[l][FRA_BW-1:0]);
        end
        default: ;
      endcase
    end
  end

`ifdef UNO_VAR_GEN_EXC_EN
  logic [LANES-1:0] w_exc_p2, r_exc_p2;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_exc_p2[l] = ((r_mode_p1 == UNO_DIV) && (r_x_p1[l] == '0)) ||
                    ((r_mode_p1 == UNO_LOG) && ($signed(r_x_p1[l]) <= 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_exc_p2 <= '0;
    else if (w_adv_p2 && r_vld_p1)  r_exc_p2 <= w_exc_p2;
  end

  assign exc_o = r_exc_p2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_mode_p2 <= UNO_GEMM;
      for (int l = 0; l < LANES; l++) begin
        r_var_p2[l] <= '0;
        r_sh_p2[l]  <= '0;
        r_int_p2[l] <= '0;
      end
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_mode_p2 <= r_mode_p1;
        for (int l = 0; l < LANES; l++) begin
`ifdef UNO_VAR_GEN_EXC_EN
          r_var_p2[l] <= w_exc_p2[l] ? '0 : w_var_p2[l];
`else
          r_var_p2[l] <= w_var_p2[l];
`endif
          r_sh_p2[l]  <= w_sh_p2[l];
          r_int_p2[l] <= w_int_p2[l];
        end
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign mode_o    = r_mode_p2;

endmodule

// File: tb/tb_uno_var_gen_pipe.sv
// Self-checking bench for uno_var_gen_pipe (LANES=4, INT_BW=5, FRA_BW=10) with
// an arithmetic reference model and a scoreboard queue; honours UNO_VAR_GEN_EXC_EN.
module tb_uno_var_gen_pipe;

  typedef struct packed {
    logic [63:0] v;
    logic [19:0] s;
    logic [23:0] i;
    logic [1:0]  m;
    logic [3:0]  e;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  gemm_uno = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] var_o;
  logic [19:0] shift_o;
  logic [23:0] int_o;
  logic [1:0]  mode_o;
  logic [3:0]  exc_w;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_out    = 0;
  res_t exp_q[$];
  res_t prev_act;
  logic stalled = 1'b0;

  always #5 clk = ~clk;

  uno_var_gen_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gemm_uno  (gemm_uno),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .var_o     (var_o),
    .shift_o   (shift_o),
    .int_o     (int_o),
    .mode_o    (mode_o)
`ifdef UNO_VAR_GEN_EXC_EN
    ,
    .exc_o     (exc_w)
`endif
  );

`ifndef UNO_VAR_GEN_EXC_EN
  assign exc_w = 4'b0000;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real-valued reasoning on the operand, expressed in integers.
  function automatic res_t model(input logic [1:0] m, input logic [63:0] xs);
    res_t r;
    r = '0;
    r.m = m;
    for (int l = 0; l < 4; l++) begin
      int ux, sx, p, sh, nrm, vv, fl;
      logic ex;
      ux = int'(xs[l*16 +: 16]);
      sx = (ux >= 32768) ? ux - 65536 : ux;
      sh = 0; vv = 0; fl = 0; ex = 1'b0;
      if (m == 2'b01 || m == 2'b11) begin
        if (ux == 0) begin
          nrm = 0;
        end else begin
          p = 0;
          while ((1 << (p + 1)) <= ux) p++;
          sh  = 9 - p;
          nrm = (sh >= 0) ? ux * (1 << sh) : ux / (1 << (-sh));
        end
        vv = (768 - nrm + 65536) % 65536;
`ifdef UNO_VAR_GEN_EXC_EN
        ex = (m == 2'b01) ? (ux == 0) : (sx <= 0);
        if (ex) vv = 0;
`endif
      end else if (m == 2'b10) begin
        fl = (sx >= 0) ? sx / 1024 : -((-sx + 1023) / 1024);
        vv = sx - fl * 1024;
      end
      r.v[l*16 +: 16] = 16'(vv);
      r.s[l*5 +: 5]   = 5'(sh);
      r.i[l*6 +: 6]   = 6'(fl);
      r.e[l]          = ex;
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_x();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'h0000;
      2:       return 16'($urandom_range(1, 255));
      default: return 16'($urandom_range(256, 32767));
    endcase
  endfunction

  function automatic logic [63:0] rnd_lanes();
    return {rnd_x(), rnd_x(), rnd_x(), rnd_x()};
  endfunction

  // Scoreboard: record accepts, compare every valid output, check stall hold.
  always @(negedge clk) begin
    res_t act;
    act = {var_o, shift_o, int_o, mode_o, exc_w};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(gemm_uno, x_i));
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data_v", act.v, prev_act.v);
        chk("stall_data_sim", {act.s, act.i, act.m, act.e}, {prev_act.s, prev_act.i, prev_act.m, prev_act.e});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("var", act.v, exp_q[0].v);
          chk("shift", act.s, exp_q[0].s);
          chk("int", act.i, exp_q[0].i);
          chk("mode", act.m, exp_q[0].m);
          chk("exc", act.e, exp_q[0].e);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      stalled  = out_valid && !out_ready;
      prev_act = act;
    end
  end

  // One beat into an idle pipeline; leaves the caller #1 after the output edge.
  task automatic beat2(input logic [1:0] m, input logic [63:0] xs);
    @(posedge clk); #1;
    gemm_uno = m; x_i = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("acc_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat2_valid", out_valid, 1);
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1; in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    logic [1:0]  bm [8];
    logic [63:0] bx [8];
    int sent, guard, out_base;
    logic rdy;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_var", var_o, 0);
    chk("rst_shift", shift_o, 0);
    chk("rst_int", int_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_exc", exc_w, 0);
    rst_n = 1'b1;

    // div: 2.0 and 0.25 both normalise to 0.5
    beat2(2'b01, {16'hFC00, 16'h0000, 16'h0100, 16'h0800});
    chk("div2_var", var_o[15:0], 16'h0100);
    chk("div2_shift", shift_o[4:0], 5'h1E);
    chk("div2_int", int_o[5:0], 6'h00);
    chk("div025_var", var_o[31:16], 16'h0100);
    chk("div025_shift", shift_o[9:5], 5'h01);
    chk("div0_shift", shift_o[14:10], 5'h00);
`ifdef UNO_VAR_GEN_EXC_EN
    chk("div0_var_exc", var_o[47:32], 16'h0000);
    chk("div0_exc", exc_w[2], 1);
    chk("divneg_exc", exc_w[3], 0);
`else
    chk("div0_var", var_o[47:32], 16'h0300);
`endif
    chk("div_mode", mode_o, 2'b01);

    // log: 3.0 -> 0.75 exactly; 1.0 -> 0.5
    beat2(2'b11, {16'h0000, 16'hFC00, 16'h0400, 16'h0C00});
    chk("log3_var", var_o[15:0], 16'h0000);
    chk("log3_shift", shift_o[4:0], 5'h1E);
    chk("log3_mode", mode_o, 2'b11);
    chk("log1_var", var_o[31:16], 16'h0100);
`ifdef UNO_VAR_GEN_EXC_EN
    chk("log1_exc", exc_w[1], 0);
    chk("logneg_exc", exc_w[2], 1);
    chk("log0_exc", exc_w[3], 1);
`endif

    // exp: -1.25 -> floor -2, fraction 0.75
    beat2(2'b10, {16'h0001, 16'h7FFF, 16'h0C00, 16'hFB00});
    chk("expneg_int", int_o[5:0], 6'h3E);
    chk("expneg_var", var_o[15:0], 16'h0300);
    chk("expneg_shift", shift_o[4:0], 5'h00);
    chk("exp3_int", int_o[11:6], 6'h03);
    chk("exp3_var", var_o[31:16], 16'h0000);

    // gemm: idle lanes
    beat2(2'b00, 64'h1234_5678_9ABC_DEF0);
    chk("gemm_var", var_o, 0);
    chk("gemm_shift", shift_o, 0);
    drain();

    // 8 back-to-back mixed beats with out_ready toggling
    for (int k = 0; k < 8; k++) begin
      bm[k] = 2'(k);
      bx[k] = rnd_lanes();
    end
    out_base = n_out;
    sent = 0; guard = 0;
    out_ready = 1'b0;
    while (sent < 8 && guard < 100) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      in_valid = 1'b1; gemm_uno = bm[sent]; x_i = bx[sent];
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) sent++;
      #1 in_valid = 1'b0;
      guard++;
    end
    chk("b2b_sent", 64'(sent), 8);
    drain();
    chk("b2b_outputs", 64'(n_out - out_base), 8);

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || rdy) begin
        in_valid = ($urandom_range(0, 2) != 0);
        gemm_uno = 2'($urandom);
        x_i      = rnd_lanes();
      end
      #1 rdy = in_ready;
    end
    drain();

    // reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; gemm_uno = 2'b01; x_i = rnd_lanes();
    @(posedge clk); #1;
    gemm_uno = 2'b10; x_i = rnd_lanes();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_var", var_o, 0);
    chk("midrst_shift", shift_o, 0);
    chk("midrst_int", int_o, 0);
    chk("midrst_mode", mode_o, 0);
    chk("midrst_exc", exc_w, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    beat2(2'b11, {16'h0400, 16'h0400, 16'h0400, 16'h0C00});
    chk("postrst_var", var_o[15:0], 16'h0000);
    chk("postrst_var1", var_o[31:16], 16'h0100);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
